csr_port_arbiter: RTL
=====================

# csr_port_arbiter

Round-robin arbiter that shares the single control-register access port (the 7-bit-address read/write port of the control register file) among `NUM_REQ` requesters, e.g. the load/store unit, debug unit and boot loader. It accepts at most one operation per cycle and drives the port from registers. It routes read data back to the originating requester, and holds writes to the SPI data register while an SPI shift is in progress.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `IN_reqValid`  in  NUM_REQ  request pending per requester.
- `IN_reqWrite`  in  NUM_REQ  1 = write, 0 = read.
- `IN_reqAddr`  in  NUM_REQ×7  register address per requester.
- `IN_reqWm`  in  NUM_REQ×4  byte write mask (writes only).
- `IN_reqData`  in  NUM_REQ×32  write data.
- `OUT_gnt`  out  NUM_REQ  one-hot grant, combinational, same cycle as accept.
- `OUT_we`  out  1  port write strobe, active-low.
- `OUT_wm`  out  4  port byte mask.
- `OUT_writeAddr`  out  7  port write address.
- `OUT_wdata`  out  32  port write data.
- `OUT_re`  out  1  port read strobe, active-low.
- `OUT_readAddr`  out  7  port read address.
- `IN_rdata`  in  32  port read data, valid 2 cycles after `OUT_re` low.
- `IN_spiBusy`  in  1  SPI shift in progress.
- `OUT_rspValid`  out  NUM_REQ  one-hot read response valid.
- `OUT_rspData`  out  32  read response data.

## Operation
- Request protocol:
  - A requester holds valid, write flag, address, mask and data stable until it sees `OUT_gnt[i]` high.
  - Grant and accept occur in the same cycle.
  - A requester may present a new request in the cycle after its grant.
- Eligibility: requester i is eligible when `IN_reqValid[i]` is high and the request is not an SPI write held back by the SPI hold rule.
  - SPI write: `IN_reqWrite[i]`, `addr[5]==0`, `addr[4:0]==4`.
  - SPI hold: active while `IN_spiBusy` is high or `spiGuard != 0`.
- Arbitration:
  - 3-bit priority pointer `ptr`.
  - Grant goes to the first eligible index scanning ptr, ptr+1, … mod NUM_REQ.
  - On grant to i, `ptr <= (i+1) mod NUM_REQ`.
  - Without a grant, `ptr` holds.
  - Ineligible requesters are skipped and never block others.
- Issue: the granted operation is registered onto the port in the next cycle.
  - Write: `OUT_we=0` with mask, address and data.
  - Read: `OUT_re=0` with address.
  - Only one of `OUT_we`/`OUT_re` is low in any cycle. Each strobe lasts exactly one cycle.
  - Without a grant, both strobes are 1; address, data and mask hold their previous values.
- SPI guard:
  - 2-bit `spiGuard` loads 3 when an SPI write is granted.
  - Otherwise it decrements while nonzero.
  - This covers the latency before the register file asserts busy.
- Response routing:
  - A 3-stage shift pipe of {valid, requester index} records each granted read.
  - When stage 3 is valid, `OUT_rspValid[idx]=1` and `OUT_rspData=IN_rdata`. Otherwise `OUT_rspValid=0`.
  - `OUT_rspData` is don't-care when not valid.
- No ordering hazard handling is needed: a read granted the cycle after a write to the same address returns the new value.

## Timing
- Reset (`rst`=0 at an edge):
  - `OUT_we=1`, `OUT_re=1`, `OUT_wm=0`, addresses 0, `OUT_wdata=0`.
  - `ptr=0`, `spiGuard=0`, response pipe cleared, so `OUT_rspValid=0`.
  - `OUT_gnt` is forced to 0 while `rst`=0.
- Reset mid-operation: in-flight reads are dropped with no response; pending requests are re-arbitrated from `ptr=0` after reset releases.
- Grant in cycle t:
  - Port strobe in cycle t+1.
  - Read response (`OUT_rspValid`) in cycle t+3.
  - Write visible to a port read issued in t+2 or later.
- Throughput: one grant per cycle; back-to-back reads yield back-to-back responses.
- SPI hold:
  - Worst case after an SPI write grant at t, the next SPI write is ineligible in t+1..t+3.
  - It then waits for `IN_spiBusy` to fall.
  - Non-SPI requests continue to be granted during the hold.
- Simultaneous events: an SPI guard load takes precedence over its decrement.

## Test plan
- Single read: requester 1 reads addr 0x03 at t with `IN_rdata`=0x1234 in t+3 -> `OUT_gnt`=3'b010 at t, `OUT_re`=0 and `OUT_readAddr`=0x03 at t+1, `OUT_rspValid`=3'b010 and data 0x1234 at t+3.
- Round-robin: all 3 request continuously from reset -> grant order 0,1,2,0,1,2; one strobe per cycle; responses 3 cycles after each grant to the matching index.
- Write: requester 2 writes addr 0x00, wm 4'b0011, data 0xDEADBEEF -> at t+1 `OUT_we`=0, `OUT_wm`=4'b0011, `OUT_wdata`=0xDEADBEEF; `OUT_re`=1.
- SPI hold: requester 0 issues two SPI writes (addr 0x04, wm 4'b1111) back-to-back; requester 1 issues reads; `IN_spiBusy` high t+3..t+66 -> second SPI write granted at t+67, reads granted in between.
- Skip: requester 0 has a held SPI write; requester 1 a read; `ptr`=0 -> requester 1 is granted and `ptr` becomes 2.
- Reset mid-flight: assert `rst`=0 one cycle after a read grant -> no `OUT_rspValid`; strobes return to 1; first grant after release goes to the lowest valid index.

Source files
------------

// File: rtl/csr_port_arbiter.sv
// Round-robin arbiter sharing the control-register access port among NUM_REQ requesters.
// Grants are combinational, the port is driven from registers one cycle later, and read
// data is routed back to the originating requester three cycles after its grant.
module csr_port_arbiter #(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]    IN_reqValid,
   input  logic [NUM_REQ-1:0]    IN_reqWrite,
   input  logic [NUM_REQ*7-1:0]  IN_reqAddr,
   input  logic [NUM_REQ*4-1:0]  IN_reqWm,
   input  logic [NUM_REQ*32-1:0] IN_reqData,
   output logic [NUM_REQ-1:0]    OUT_gnt,
   output logic                 OUT_we,
   output logic [3:0]           OUT_wm,
   output logic [6:0]           OUT_writeAddr,
   output logic [31:0]          OUT_wdata,
   output logic                 OUT_re,
   output logic [6:0]           OUT_readAddr,
   input  logic [31:0]          IN_rdata,
   input  logic                 IN_spiBusy,
   output logic [NUM_REQ-1:0]    OUT_rspValid,
   output logic [31:0]          OUT_rspData
);

   logic [2:0]         ptr_q, ptr_d;
   logic [1:0]         spi_guard_q, spi_guard_d;
   logic               we_q, we_d;
   logic               re_q, re_d;
   logic [3:0]         wm_q, wm_d;
   logic [6:0]         waddr_q, waddr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [6:0]         raddr_q, raddr_d;
   logic [2:0]         pipe_vld_q, pipe_vld_d;
   logic [2:0][2:0]    pipe_idx_q, pipe_idx_d;

   logic               spi_hold;
   logic [NUM_REQ-1:0] spi_wr;
   logic [NUM_REQ-1:0] elig;
   logic               gnt_found;
   logic               gnt_valid;
   logic [2:0]         gnt_idx;
   logic               sel_write;
   logic               sel_spi;
   logic [6:0]         sel_addr;
   logic [3:0]         sel_wm;
   logic [31:0]        sel_data;

   // ptr + offset wrapped into 0..NUM_REQ-1; the sum never reaches 2*NUM_REQ
   function automatic logic [2:0] wrap_idx(input int unsigned v);
      if (v >= NUM_REQ) begin
         return 3'(v - NUM_REQ);
      end
      return 3'(v);
   endfunction

   // Eligibility and round-robin scan starting at ptr
   always_comb begin
      spi_hold  = IN_spiBusy | (spi_guard_q != 2'd0);
      spi_wr    = '0;
      elig      = '0;
      gnt_found = 1'b0;
      gnt_idx   = 3'd0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         spi_wr[i] = IN_reqWrite[i] & ~IN_reqAddr[i*7+5] & (IN_reqAddr[i*7 +: 5] == 5'd4);
         elig[i]   = IN_reqValid[i] & ~(spi_wr[i] & spi_hold);
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && elig[i] && (wrap_idx(32'(ptr_q) + k) == 3'(i))) begin
               gnt_found = 1'b1;
               gnt_idx   = 3'(i);
            end
         end
      end
      // No grants may be issued while reset is asserted
      gnt_valid = gnt_found & rst;
   end

   // Select the winning request's fields and form the one-hot grant
   always_comb begin
      sel_write = 1'b0;
      sel_spi   = 1'b0;
      sel_addr  = 7'd0;
      sel_wm    = 4'd0;
      sel_data  = 32'd0;
      OUT_gnt   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == 3'(i)) begin
            sel_write = IN_reqWrite[i];
            sel_spi   = spi_wr[i];
            sel_addr  = IN_reqAddr[i*7 +: 7];
            sel_wm    = IN_reqWm[i*4 +: 4];
            sel_data  = IN_reqData[i*32 +: 32];
         end
         OUT_gnt[i] = gnt_valid & (gnt_idx == 3'(i));
      end
   end

   // Next state: pointer, SPI guard, port registers and response pipe
   always_comb begin
      ptr_d       = ptr_q;
      spi_guard_d = spi_guard_q;
      we_d        = 1'b1;
      re_d        = 1'b1;
      wm_d        = wm_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      raddr_d     = raddr_q;
      pipe_vld_d  = {pipe_vld_q[1:0], gnt_valid & ~sel_write};
      pipe_idx_d  = {pipe_idx_q[1], pipe_idx_q[0], gnt_idx};

      if (gnt_valid) begin
         ptr_d = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
      end

      // A fresh SPI write grant reloads the guard ahead of any decrement
      if (gnt_valid && sel_spi) begin
         spi_guard_d = 2'd3;
      end else if (spi_guard_q != 2'd0) begin
         spi_guard_d = spi_guard_q - 2'd1;
      end

      if (gnt_valid) begin
         if (sel_write) begin
            we_d    = 1'b0;
            wm_d    = sel_wm;
            waddr_d = sel_addr;
            wdata_d = sel_data;
         end else begin
            re_d    = 1'b0;
            raddr_d = sel_addr;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q       <= 3'd0;
         spi_guard_q <= 2'd0;
         we_q        <= 1'b1;
         re_q        <= 1'b1;
         wm_q        <= 4'd0;
         waddr_q     <= 7'd0;
         wdata_q     <= 32'd0;
         raddr_q     <= 7'd0;
         pipe_vld_q  <= 3'd0;
         pipe_idx_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         spi_guard_q <= spi_guard_d;
         we_q        <= we_d;
         re_q        <= re_d;
         wm_q        <= wm_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         raddr_q     <= raddr_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_idx_q  <= pipe_idx_d;
      end
   end

   // Port outputs come straight from registers; responses decode the last pipe stage
   always_comb begin
      OUT_we        = we_q;
      OUT_re        = re_q;
      OUT_wm        = wm_q;
      OUT_writeAddr = waddr_q;
      OUT_wdata     = wdata_q;
      OUT_readAddr  = raddr_q;
      OUT_rspData   = IN_rdata;
      OUT_rspValid  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         OUT_rspValid[i] = pipe_vld_q[2] & (pipe_idx_q[2] == 3'(i));
      end
   end

endmodule
